// File: rtl/usb_ep_protocol_ctrl.sv
// usb_ep_protocol_ctrl
//   Sequences USB OUT and IN transactions for NUM_EP endpoints between the RX decoder,
//   TX encoder, data buffer and the AHB-side status registers. Per endpoint it keeps the
//   expected RX and next TX DATA0/DATA1 toggle, honours stall and buffer-reserved state,
//   and bounds every wait on the TX encoder so the bus side cannot hang.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   rx_packet            RX event (0 idle, 1 OUT, 2 data, 3 RX err, 4 RX busy, 5 TX err, 6 IN)
//   rx_ep                endpoint of the current token
//   rx_pid_toggle        DATA0/DATA1 of the received data packet
//   buffer_reserved      per-endpoint buffer held by the AHB side
//   buffer_occupancy     bytes currently in the data buffer
//   tx_status            TX encoder finished the current packet (pulse)
//   ep_stall             per-endpoint halt
//   ep_toggle_clr        force both toggles of an endpoint back to DATA0
//   rx_data_ready .. tx_error   AHB status flags
//   d_mode               device drives the bus (IN transaction)
//   tx_packet            packet request to the TX encoder (0 idle, 1 data, 2 ACK, 3 NACK, 4 STALL)
//   tx_toggle            DATA PID toggle for the packet being sent
//   clear                flush the data buffer (pulse)
//   active_ep            endpoint of the current transaction
//   timeout_err          TX encoder wait expired (pulse)
module usb_ep_protocol_ctrl #(
  parameter int unsigned NUM_EP      = 2,
  parameter int unsigned BUF_DEPTH   = 64,
  parameter int unsigned TIMEOUT_CYC = 32,
  localparam int unsigned EPW  = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
  localparam int unsigned OCCW = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        rx_packet,
  input  logic [EPW-1:0]    rx_ep,
  input  logic              rx_pid_toggle,
  input  logic [NUM_EP-1:0] buffer_reserved,
  input  logic [OCCW-1:0]   buffer_occupancy,
  input  logic              tx_status,
  input  logic [NUM_EP-1:0] ep_stall,
  input  logic [NUM_EP-1:0] ep_toggle_clr,
  output logic              rx_data_ready,
  output logic              rx_transfer_active,
  output logic              rx_error,
  output logic              tx_transfer_active,
  output logic              tx_error,
  output logic              d_mode,
  output logic [2:0]        tx_packet,
  output logic              tx_toggle,
  output logic              clear,
  output logic [EPW-1:0]    active_ep,
  output logic              timeout_err
);

  localparam int unsigned CNTW = $clog2(TIMEOUT_CYC);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StRxActive = 4'd1;
  localparam logic [3:0] StRxDone   = 4'd2;
  localparam logic [3:0] StRxError  = 4'd3;
  localparam logic [3:0] StRxHs     = 4'd4;
  localparam logic [3:0] StTxStart  = 4'd5;
  localparam logic [3:0] StTxData   = 4'd6;
  localparam logic [3:0] StTxHs     = 4'd7;
  localparam logic [3:0] StTxError  = 4'd8;
  localparam logic [3:0] StTimeout  = 4'd9;

  localparam logic [2:0] RxOutTok = 3'd1;
  localparam logic [2:0] RxData   = 3'd2;
  localparam logic [2:0] RxErr    = 3'd3;
  localparam logic [2:0] RxBusy   = 3'd4;
  localparam logic [2:0] RxTxErr  = 3'd5;
  localparam logic [2:0] RxInTok  = 3'd6;

  localparam logic [2:0] PktData  = 3'd1;
  localparam logic [2:0] PktAck   = 3'd2;
  localparam logic [2:0] PktNack  = 3'd3;
  localparam logic [2:0] PktStall = 3'd4;

  logic [3:0]        state_q, state_d;
  logic [EPW-1:0]    active_ep_q, active_ep_d;
  logic [2:0]        hs_q, hs_d;
  logic              accept_q, accept_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [NUM_EP-1:0] rx_tog_q, rx_tog_d;
  logic [NUM_EP-1:0] tx_tog_q, tx_tog_d;

  logic ep_valid;
  logic overflow;
  logic expired;
  logic waiting_d;

  assign ep_valid  = 32'(rx_ep) < NUM_EP;
  assign overflow  = buffer_occupancy >= OCCW'(BUF_DEPTH);
  assign expired   = cnt_q == CNTW'(TIMEOUT_CYC - 1);
  assign waiting_d = state_d inside {StRxHs, StTxData, StTxHs};
  assign active_ep = active_ep_q;

  always_comb begin
    state_d     = state_q;
    active_ep_d = active_ep_q;
    hs_d        = hs_q;
    accept_d    = accept_q;
    rx_tog_d    = rx_tog_q;
    tx_tog_d    = tx_tog_q;

    case (state_q)
      StIdle: begin
        // Tokens addressing a non-existent endpoint are dropped.
        if ((rx_packet == RxOutTok || rx_packet == RxInTok) && ep_valid) begin
          active_ep_d = rx_ep;
          state_d     = (rx_packet == RxOutTok) ? StRxActive : StTxStart;
        end else if (rx_packet == RxTxErr) begin
          state_d = StTxError;
        end
      end
      StRxActive: begin
        if (rx_packet == RxErr || (rx_packet == RxBusy && overflow)) begin
          state_d = StRxError;
        end else if (rx_packet == RxData) begin
          state_d  = StRxDone;
          accept_d = 1'b0;
          if (ep_stall[active_ep_q]) begin
            hs_d = PktStall;
          end else if (buffer_reserved[active_ep_q]) begin
            hs_d = PktNack;
          end else begin
            // A toggle mismatch is a retransmission: ACK it but drop the data.
            hs_d     = PktAck;
            accept_d = rx_pid_toggle == rx_tog_q[active_ep_q];
          end
        end
      end
      StRxDone: begin
        if (accept_q) begin
          rx_tog_d[active_ep_q] = ~rx_tog_q[active_ep_q];
        end
        state_d = StRxHs;
      end
      StRxHs, StTxHs: begin
        if (tx_status) begin
          state_d = StIdle;
        end else if (expired) begin
          state_d = StTimeout;
        end
      end
      StTxStart: begin
        if (ep_stall[active_ep_q]) begin
          hs_d    = PktStall;
          state_d = StTxHs;
        end else if (buffer_reserved[active_ep_q] || buffer_occupancy == '0) begin
          hs_d    = PktNack;
          state_d = StTxHs;
        end else begin
          state_d = StTxData;
        end
      end
      StTxData: begin
        if (tx_status) begin
          tx_tog_d[active_ep_q] = ~tx_tog_q[active_ep_q];
          state_d               = StIdle;
        end else if (expired) begin
          state_d = StTimeout;
        end
      end
      default: state_d = StIdle;
    endcase

    // Host-requested toggle reset overrides any flip in the same cycle.
    for (int e = 0; e < int'(NUM_EP); e++) begin
      if (ep_toggle_clr[e]) begin
        rx_tog_d[e] = 1'b0;
        tx_tog_d[e] = 1'b0;
      end
    end

    // Wait states are only entered from non-wait states, so staying means counting.
    cnt_d = (waiting_d && state_d == state_q) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      active_ep_q <= '0;
      hs_q        <= '0;
      accept_q    <= 1'b0;
      cnt_q       <= '0;
      rx_tog_q    <= '0;
      tx_tog_q    <= '0;
    end else begin
      state_q     <= state_d;
      active_ep_q <= active_ep_d;
      hs_q        <= hs_d;
      accept_q    <= accept_d;
      cnt_q       <= cnt_d;
      rx_tog_q    <= rx_tog_d;
      tx_tog_q    <= tx_tog_d;
    end
  end

  always_comb begin
    rx_data_ready      = 1'b0;
    rx_transfer_active = 1'b0;
    rx_error           = 1'b0;
    tx_transfer_active = 1'b0;
    tx_error           = 1'b0;
    d_mode             = 1'b0;
    tx_packet          = 3'd0;
    tx_toggle          = 1'b0;
    clear              = 1'b0;
    timeout_err        = 1'b0;
    case (state_q)
      StRxActive: rx_transfer_active = 1'b1;
      StRxDone: begin
        rx_data_ready = accept_q;
        clear         = ~accept_q;
      end
      StRxError: begin
        rx_error = 1'b1;
        clear    = 1'b1;
      end
      StRxHs: tx_packet = hs_q;
      StTxStart: d_mode = 1'b1;
      StTxData: begin
        tx_packet          = PktData;
        tx_transfer_active = 1'b1;
        d_mode             = 1'b1;
        tx_toggle          = tx_tog_q[active_ep_q];
      end
      StTxHs: begin
        tx_packet = hs_q;
        d_mode    = 1'b1;
      end
      StTxError: begin
        tx_error = 1'b1;
        clear    = 1'b1;
      end
      StTimeout: begin
        tx_error    = 1'b1;
        timeout_err = 1'b1;
        clear       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usb_ep_protocol_ctrl.sv
module tb_usb_ep_protocol_ctrl;

  localparam int NUM_EP      = 2;
  localparam int BUF_DEPTH   = 64;
  localparam int TIMEOUT_CYC = 32;
  localparam int EPW         = 1;
  localparam int OCCW        = 7;

  // Transaction phases as seen on the outputs.
  localparam int PIdle    = 0;
  localparam int PRxAct   = 1;
  localparam int PRxAcc   = 2;
  localparam int PRxDisc  = 3;
  localparam int PRxErr   = 4;
  localparam int PRxHs    = 5;
  localparam int PTxStart = 6;
  localparam int PTxData  = 7;
  localparam int PTxHs    = 8;
  localparam int PTxErr   = 9;
  localparam int PTo      = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        rx_packet;
  logic [EPW-1:0]    rx_ep;
  logic              rx_pid_toggle;
  logic [NUM_EP-1:0] buffer_reserved;
  logic [OCCW-1:0]   buffer_occupancy;
  logic              tx_status;
  logic [NUM_EP-1:0] ep_stall;
  logic [NUM_EP-1:0] ep_toggle_clr;
  logic              rx_data_ready, rx_transfer_active, rx_error;
  logic              tx_transfer_active, tx_error, d_mode;
  logic [2:0]        tx_packet;
  logic              tx_toggle, clear, timeout_err;
  logic [EPW-1:0]    active_ep;

  typedef struct packed {
    logic           rdr;
    logic           rta;
    logic           rerr;
    logic           tta;
    logic           terr;
    logic           dm;
    logic [2:0]     txp;
    logic           ttog;
    logic           clr;
    logic [EPW-1:0] aep;
    logic           to;
  } outs_t;

  outs_t act, exp_o;
  bit    chk_en = 1'b0;
  string cur_name = "reset";
  int    checks = 0;
  int    errors = 0;

  // Literal checks are handed to the compare process so one process owns the counters.
  bit    lit_req = 1'b0;
  string lit_name = "";
  int    lit_got, lit_want;

  // Output-event counters observed from the DUT pins.
  int n_rdr = 0, n_clr = 0, n_to = 0, last_txp = 0;
  int b_rdr, b_clr, b_to;

  // Model state.
  bit [NUM_EP-1:0] m_rx_tog, m_tx_tog;
  int              m_ep;

  always #5 clk = ~clk;

  usb_ep_protocol_ctrl #(
    .NUM_EP     (NUM_EP),
    .BUF_DEPTH  (BUF_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_packet         (rx_packet),
    .rx_ep             (rx_ep),
    .rx_pid_toggle     (rx_pid_toggle),
    .buffer_reserved   (buffer_reserved),
    .buffer_occupancy  (buffer_occupancy),
    .tx_status         (tx_status),
    .ep_stall          (ep_stall),
    .ep_toggle_clr     (ep_toggle_clr),
    .rx_data_ready     (rx_data_ready),
    .rx_transfer_active(rx_transfer_active),
    .rx_error          (rx_error),
    .tx_transfer_active(tx_transfer_active),
    .tx_error          (tx_error),
    .d_mode            (d_mode),
    .tx_packet         (tx_packet),
    .tx_toggle         (tx_toggle),
    .clear             (clear),
    .active_ep         (active_ep),
    .timeout_err       (timeout_err)
  );

  assign act = {rx_data_ready, rx_transfer_active, rx_error, tx_transfer_active, tx_error,
                d_mode, tx_packet, tx_toggle, clear, active_ep, timeout_err};

  always @(negedge clk) begin
    if (lit_req) begin
      checks++;
      if (lit_got != lit_want) begin
        errors++;
        $display("FAIL %s: got %0d want %0d", lit_name, lit_got, lit_want);
      end
    end
    if (chk_en) begin
      checks++;
      if (act !== exp_o) begin
        errors++;
        $display("FAIL %s @%0t: outputs got %b want %b (rdr rta rerr tta terr dm txp tog clr ep to)",
                 cur_name, $time, act, exp_o);
      end
      if (rx_data_ready) n_rdr++;
      if (clear) n_clr++;
      if (timeout_err) n_to++;
      if (tx_packet != 3'd0) last_txp = int'(tx_packet);
    end
  end

  // Expected outputs for a phase of a transaction on the current endpoint.
  function automatic outs_t vec(input int ph, input logic [2:0] pkt, input logic tog);
    outs_t o;
    o = '0;
    o.aep = EPW'(m_ep);
    case (ph)
      PRxAct:   o.rta = 1'b1;
      PRxAcc:   o.rdr = 1'b1;
      PRxDisc:  o.clr = 1'b1;
      PRxErr:   begin o.rerr = 1'b1; o.clr = 1'b1; end
      PRxHs:    o.txp = pkt;
      PTxStart: o.dm = 1'b1;
      PTxData:  begin o.txp = 3'd1; o.tta = 1'b1; o.dm = 1'b1; o.ttog = tog; end
      PTxHs:    begin o.txp = pkt; o.dm = 1'b1; end
      PTxErr:   begin o.terr = 1'b1; o.clr = 1'b1; end
      PTo:      begin o.terr = 1'b1; o.to = 1'b1; o.clr = 1'b1; end
      default:  ;
    endcase
    return o;
  endfunction

  task automatic tick(input outs_t e);
    @(posedge clk);
    #1;
    exp_o = e;
  endtask

  task automatic lit(input string nm, input int got, input int want);
    lit_name = nm;
    lit_got  = got;
    lit_want = want;
    lit_req  = 1'b1;
    @(negedge clk);
    #1;
    lit_req = 1'b0;
  endtask

  task automatic snap();
    b_rdr = n_rdr;
    b_clr = n_clr;
    b_to  = n_to;
  endtask

  // Waits on the TX encoder; status_at is the wait cycle (1-based) carrying tx_status, 0 = never.
  task automatic wait_phase(input outs_t w, input int status_at, output bit ok);
    ok = 1'b0;
    for (int c = 1; c <= TIMEOUT_CYC; c++) begin
      tick(w);
      ep_toggle_clr = '0;
      if (c == status_at) begin
        tx_status = 1'b1;
        tick(vec(PIdle, 3'd0, 1'b0));
        tx_status = 1'b0;
        ok = 1'b1;
        return;
      end
    end
    tick(vec(PTo, 3'd0, 1'b0));
    tick(vec(PIdle, 3'd0, 1'b0));
  endtask

  task automatic out_txn(input string nm, input int ep, input bit pid, input logic [1:0] res,
                         input logic [1:0] stl, input logic [1:0] clr, input int status_at);
    logic [2:0] hs;
    bit acc, ok;
    cur_name = nm;
    buffer_reserved = res;
    ep_stall = stl;
    rx_packet = 3'd1;
    rx_ep = EPW'(ep);
    m_ep = ep;
    tick(vec(PRxAct, 3'd0, 1'b0));
    rx_packet = 3'd2;
    rx_pid_toggle = pid;
    acc = 1'b0;
    if (stl[ep]) hs = 3'd4;
    else if (res[ep]) hs = 3'd3;
    else begin
      hs = 3'd2;
      acc = (pid == m_rx_tog[ep]);
    end
    tick(vec(acc ? PRxAcc : PRxDisc, 3'd0, 1'b0));
    rx_packet = 3'd0;
    ep_toggle_clr = clr;
    if (acc) m_rx_tog[ep] = ~m_rx_tog[ep];
    m_rx_tog &= ~clr;
    m_tx_tog &= ~clr;
    wait_phase(vec(PRxHs, hs, 1'b0), status_at, ok);
    buffer_reserved = '0;
    ep_stall = '0;
  endtask

  task automatic in_txn(input string nm, input int ep, input int occ, input logic [1:0] res,
                        input logic [1:0] stl, input int status_at);
    bit ok;
    cur_name = nm;
    buffer_reserved = res;
    ep_stall = stl;
    buffer_occupancy = OCCW'(occ);
    rx_packet = 3'd6;
    rx_ep = EPW'(ep);
    m_ep = ep;
    tick(vec(PTxStart, 3'd0, 1'b0));
    rx_packet = 3'd0;
    if (stl[ep]) wait_phase(vec(PTxHs, 3'd4, 1'b0), status_at, ok);
    else if (res[ep] || occ == 0) wait_phase(vec(PTxHs, 3'd3, 1'b0), status_at, ok);
    else begin
      wait_phase(vec(PTxData, 3'd1, m_tx_tog[ep]), status_at, ok);
      if (ok) m_tx_tog[ep] = ~m_tx_tog[ep];
    end
    buffer_reserved = '0;
    ep_stall = '0;
  endtask

  // OUT token, then an error event (optionally preceded by a non-overflowing busy).
  task automatic rx_err_txn(input string nm, input int ep, input logic [2:0] ev, input int occ,
                            input bit benign_busy);
    cur_name = nm;
    rx_packet = 3'd1;
    rx_ep = EPW'(ep);
    m_ep = ep;
    tick(vec(PRxAct, 3'd0, 1'b0));
    if (benign_busy) begin
      rx_packet = 3'd4;
      buffer_occupancy = OCCW'(BUF_DEPTH - 1);
      tick(vec(PRxAct, 3'd0, 1'b0));
    end
    rx_packet = ev;
    buffer_occupancy = OCCW'(occ);
    tick(vec(PRxErr, 3'd0, 1'b0));
    rx_packet = 3'd0;
    tick(vec(PIdle, 3'd0, 1'b0));
  endtask

  initial begin
    rst = 1'b1;
    rx_packet = '0;
    rx_ep = '0;
    rx_pid_toggle = 1'b0;
    buffer_reserved = '0;
    buffer_occupancy = '0;
    tx_status = 1'b0;
    ep_stall = '0;
    ep_toggle_clr = '0;
    m_rx_tog = '0;
    m_tx_tog = '0;
    m_ep = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_o = vec(PIdle, 3'd0, 1'b0);
    chk_en = 1'b1;
    tick(vec(PIdle, 3'd0, 1'b0));
    rst = 1'b0;
    tick(vec(PIdle, 3'd0, 1'b0));

    // OUT: accept, then duplicate, then the other toggle.
    snap();
    out_txn("out_ep1_accept", 1, 1'b0, 2'b00, 2'b00, 2'b00, 2);
    lit("out_ep1_accept rdr pulses", n_rdr - b_rdr, 1);
    lit("out_ep1_accept clear pulses", n_clr - b_clr, 0);
    lit("out_ep1_accept handshake", last_txp, 2);
    snap();
    out_txn("out_ep1_dup", 1, 1'b0, 2'b00, 2'b00, 2'b00, 1);
    lit("out_ep1_dup rdr pulses", n_rdr - b_rdr, 0);
    lit("out_ep1_dup clear pulses", n_clr - b_clr, 1);
    out_txn("out_ep1_data1", 1, 1'b1, 2'b00, 2'b00, 2'b00, 3);
    out_txn("out_ep0_reserved", 0, 1'b0, 2'b01, 2'b00, 2'b00, 1);
    lit("out_ep0_reserved handshake", last_txp, 3);
    out_txn("out_ep0_stall", 0, 1'b0, 2'b01, 2'b01, 2'b00, 1);
    lit("out_ep0_stall handshake", last_txp, 4);
    out_txn("out_ep0_clr", 0, 1'b0, 2'b00, 2'b00, 2'b01, 1);
    out_txn("out_ep0_after_clr", 0, 1'b0, 2'b00, 2'b00, 2'b00, 1);
    snap();
    out_txn("out_ep0_hs_timeout", 0, 1'b1, 2'b00, 2'b00, 2'b00, 0);
    lit("out_ep0_hs_timeout pulses", n_to - b_to, 1);

    // IN transactions.
    in_txn("in_ep1_data0", 1, 10, 2'b00, 2'b00, 1);
    in_txn("in_ep1_data1", 1, 10, 2'b00, 2'b00, 3);
    lit("in_ep1_data1 last packet", last_txp, 1);
    in_txn("in_ep0_empty", 0, 0, 2'b00, 2'b00, 2);
    lit("in_ep0_empty handshake", last_txp, 3);
    in_txn("in_ep0_stall", 0, 10, 2'b01, 2'b01, 1);
    lit("in_ep0_stall handshake", last_txp, 4);
    in_txn("in_ep0_reserved", 0, 10, 2'b01, 2'b00, 1);
    snap();
    in_txn("in_ep1_timeout", 1, 10, 2'b00, 2'b00, 0);
    lit("in_ep1_timeout pulses", n_to - b_to, 1);
    lit("in_ep1_timeout clear pulses", n_clr - b_clr, 1);
    in_txn("in_ep1_last_cycle", 1, 10, 2'b00, 2'b00, TIMEOUT_CYC);

    // Error paths.
    snap();
    rx_err_txn("rx_overflow", 1, 3'd4, BUF_DEPTH, 1'b1);
    lit("rx_overflow clear pulses", n_clr - b_clr, 1);
    lit("rx_overflow handshake", last_txp, 1);
    rx_err_txn("rx_error", 0, 3'd3, 5, 1'b0);
    cur_name = "tx_error";
    rx_packet = 3'd5;
    tick(vec(PTxErr, 3'd0, 1'b0));
    rx_packet = 3'd0;
    tick(vec(PIdle, 3'd0, 1'b0));

    // Reset in the middle of a data IN.
    cur_name = "rst_mid_tx";
    buffer_occupancy = OCCW'(10);
    rx_packet = 3'd6;
    rx_ep = EPW'(1);
    m_ep = 1;
    tick(vec(PTxStart, 3'd0, 1'b0));
    rx_packet = 3'd0;
    tick(vec(PTxData, 3'd1, m_tx_tog[1]));
    lit("rst_mid_tx toggle before reset", int'(tx_toggle), 1);
    rst = 1'b1;
    m_ep = 0;
    m_rx_tog = '0;
    m_tx_tog = '0;
    tick(vec(PIdle, 3'd0, 1'b0));
    rst = 1'b0;
    tick(vec(PIdle, 3'd0, 1'b0));
    in_txn("in_ep1_post_reset", 1, 10, 2'b00, 2'b00, 1);
    snap();
    out_txn("out_ep1_post_reset", 1, 1'b0, 2'b00, 2'b00, 2'b00, 1);
    lit("out_ep1_post_reset rdr pulses", n_rdr - b_rdr, 1);

    chk_en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
